pc_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipeline. Owns the program counter register and drives PCOut into the existing PCAdder, then consumes that adder's PC+2 result as the sequential next PC. Issues single-outstanding requests to instruction memory and fills the IF/ID pipeline register. Handles stall, branch redirect and exception redirect.

---
 rtl/pc_fetch_pkg.sv | 30 +++
 rtl/pc_next_mux.sv | 48 ++++
 rtl/pc_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_pkg
// Purpose  : Shared definitions for the instruction-fetch stage. Contains the
//            address width, the reset and exception vectors, the fetch FSM
//            state encoding and the IF/ID payload record.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

  localparam int              ADDR_W    = 16;
  localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;
  localparam logic [ADDR_W-1:0] EXC_VEC   = 16'h0040;

  // BOOT : idle for one cycle after reset, no request issued
  // REQ  : request outstanding at the current PC
  // HOLD : an instruction arrived during a stall and is parked locally
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ifid_payload_t;

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Priority selector for the next program counter.
//            Priority: exception vector > branch target (bit 0 cleared)
//                      > PC+2 (when the stage advances) > current PC.
// Ports    : i_pc            - current PC register
//            i_pc_plus2      - PC+2 from the external adder
//            i_branch_target - redirect address from a later stage
//            i_exception     - exception redirect request
//            i_branch_taken  - branch redirect request
//            i_advance       - the stage consumed an instruction this cycle
//            o_pc_next       - selected next PC
//            o_redirect      - either redirect request is active
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_mux #(
  parameter int                ADDR_W  = pc_fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VEC = pc_fetch_pkg::EXC_VEC
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_pc_plus2,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_exception,
  input  logic              i_branch_taken,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_redirect
);

  // Instructions are halfword aligned, so a branch can never land on an odd PC.
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~{{(ADDR_W-1){1'b0}}, 1'b1};

  assign o_redirect = i_exception | i_branch_taken;

  always_comb begin
    o_pc_next = i_pc;
    if (i_exception) begin
      o_pc_next = EXC_VEC;
    end else if (i_branch_taken) begin
      o_pc_next = i_branch_target & C_ALIGN_MASK;
    end else if (i_advance) begin
      o_pc_next = i_pc_plus2;
    end
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_stage
// Purpose  : Instruction-fetch stage. Owns the PC register, issues a single
//            outstanding request to instruction memory, fills the IF/ID
//            register and handles stall, branch and exception redirects.
// Ports    : Clk, Rst       - clock, synchronous active-high reset
//            PCPlus2        - PC+2 from the external adder fed by PCOut
//            PCOut          - current PC register
//            Stall          - hold IF/ID and PC
//            BranchTaken    - redirect request, target in BranchTarget
//            BranchTarget   - redirect address (bit 0 ignored)
//            Exception      - redirect to EXC_VEC, beats BranchTaken
//            IMemReq        - fetch request (level)
//            IMemAddr       - fetch address, always PCOut
//            IMemReady      - IMemData valid for the current IMemAddr
//            IMemData       - fetched instruction
//            IFIDValid      - IF/ID register holds a valid instruction
//            IFIDInstr      - fetched instruction
//            IFIDPC         - address of IFIDInstr
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_stage
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W    = pc_fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = pc_fetch_pkg::RESET_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = pc_fetch_pkg::EXC_VEC
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PCPlus2,
  output logic [ADDR_W-1:0] PCOut,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Exception,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemReady,
  input  logic [ADDR_W-1:0] IMemData,
  output logic              IFIDValid,
  output logic [ADDR_W-1:0] IFIDInstr,
  output logic [ADDR_W-1:0] IFIDPC
);

  fetch_state_e  state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  ifid_payload_t ifid_q,  ifid_d;
  ifid_payload_t hold_q,  hold_d;

  logic w_advance;
  logic w_redirect;

  pc_next_mux #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_pc_next_mux (
    .i_pc            (pc_q),
    .i_pc_plus2      (PCPlus2),
    .i_branch_target (BranchTarget),
    .i_exception     (Exception),
    .i_branch_taken  (BranchTaken),
    .i_advance       (w_advance),
    .o_pc_next       (pc_d),
    .o_redirect      (w_redirect)
  );

  // Next-state / datapath control. A redirect wins over everything else,
  // including Stall, and drops any data returned in the same cycle.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ifid_d    = ifid_q;
    hold_d    = hold_q;
    w_advance = 1'b0;

    if (w_redirect) begin
      state_d = REQ;
      valid_d = 1'b0;
      // Parked instruction belongs to the squashed path.
      hold_d  = '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = REQ;
        end
        REQ: begin
          if (IMemReady && !Stall) begin
            ifid_d.instr = IMemData;
            ifid_d.pc    = pc_q;
            valid_d      = 1'b1;
            w_advance    = 1'b1;
          end else if (IMemReady && Stall) begin
            // Memory will not repeat the beat, so park it until ID frees up.
            hold_d.instr = IMemData;
            hold_d.pc    = pc_q;
            state_d      = HOLD;
          end else if (!Stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifid_d    = hold_q;
            valid_d   = 1'b1;
            w_advance = 1'b1;
            state_d   = REQ;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      ifid_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifid_q  <= ifid_d;
      hold_q  <= hold_d;
    end
  end

  assign PCOut     = pc_q;
  assign IMemReq   = (state_q == REQ);
  assign IMemAddr  = pc_q;
  assign IFIDValid = valid_q;
  assign IFIDInstr = ifid_q.instr;
  assign IFIDPC    = ifid_q.pc;

endmodule : pc_fetch_stage
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_stage
// Purpose  : Self-checking bench for pc_fetch_stage. Each vector gives the
//            inputs applied before a rising edge and the outputs expected
//            after it. Expectations are queued when a vector is driven and
//            popped for comparison once the DUT has clocked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_stage;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        exc;
    logic        ready;
    logic [15:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_ifpc;
  } vec_t;

  logic        Clk;
  logic        Rst;
  logic [15:0] PCPlus2;
  logic [15:0] PCOut;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        Exception;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemReady;
  logic [15:0] IMemData;
  logic        IFIDValid;
  logic [15:0] IFIDInstr;
  logic [15:0] IFIDPC;

  int n_checks;
  int n_fails;

  vec_t vecs[$];
  vec_t exp_q[$];

  pc_fetch_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PCPlus2      (PCPlus2),
    .PCOut        (PCOut),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Exception    (Exception),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemData     (IMemData),
    .IFIDValid    (IFIDValid),
    .IFIDInstr    (IFIDInstr),
    .IFIDPC       (IFIDPC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External PC adder and combinational instruction memory contents.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1111;
      16'h0002: mem_word = 16'h2222;
      16'h0004: mem_word = 16'h3333;
      16'h0006: mem_word = 16'h4444;
      16'hFFFE: mem_word = 16'hABCD;
      default:  mem_word = ~a;
    endcase
  endfunction

  assign PCPlus2  = PCOut + 16'd2;
  assign IMemData = mem_word(IMemAddr);

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [15:0] tgt, input logic exc, input logic ready,
                              input logic [15:0] e_pc, input logic e_req, input logic e_valid,
                              input logic [15:0] e_instr, input logic [15:0] e_ifpc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.exc = exc; v.ready = ready;
    v.e_pc = e_pc; v.e_req = e_req; v.e_valid = e_valid; v.e_instr = e_instr; v.e_ifpc = e_ifpc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    Rst          = v.rst;
    Stall        = v.stall;
    BranchTaken  = v.br;
    BranchTarget = v.tgt;
    Exception    = v.exc;
    IMemReady    = v.ready;
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk("PCOut",     idx, PCOut,            e.e_pc);
    chk("IMemAddr",  idx, IMemAddr,         e.e_pc);
    chk("IMemReq",   idx, {15'd0, IMemReq}, {15'd0, e.e_req});
    chk("IFIDValid", idx, {15'd0, IFIDValid}, {15'd0, e.e_valid});
    chk("IFIDInstr", idx, IFIDInstr,        e.e_instr);
    chk("IFIDPC",    idx, IFIDPC,           e.e_ifpc);
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    Rst          = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 16'h0000;
    Exception    = 1'b0;
    IMemReady    = 1'b1;

    //            rst st br tgt       ex rdy  pc        req vld instr     ifpc
    // Reset for two cycles with memory ready, first post-reset cycle is BOOT.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    // Zero-wait streaming.
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 1, 16'h2222, 16'h0002));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0006, 1, 1, 16'h3333, 16'h0004));
    // Reset while a request is being answered: no IF/ID load, everything cleared.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 16'h1111, 16'h0000));
    // Two wait states at 0002: bubbles, address stable.
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 1, 16'h2222, 16'h0002));
    // Stall while ready: restart at 0000, then 2222 arrives under stall.
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 1, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 0, 1, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0002, 0, 1, 16'h1111, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 1, 16'h2222, 16'h0002));
    // Stall with no data in REQ: everything held, valid kept.
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0004, 1, 1, 16'h2222, 16'h0002));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Redirect during a stall in HOLD: hold buffer (0004,3333) must be discarded.
    step(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0004, 0, 1, 16'h2222, 16'h0002), 100);
    step(mk(0, 1, 1, 16'h0101, 0, 1, 16'h0100, 1, 0, 16'h2222, 16'h0002), 101);
    step(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0100, 1, 0, 16'h2222, 16'h0002), 102);
    step(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0102, 1, 1, 16'hFEFF, 16'h0100), 103);

    // Exception beats branch; data returned in the redirect cycle is dropped.
    step(mk(0, 0, 1, 16'h0200, 1, 1, 16'h0040, 1, 0, 16'hFEFF, 16'h0100), 110);
    step(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0042, 1, 1, 16'hFFBF, 16'h0040), 111);

    // Redirect taken straight out of BOOT.
    step(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000), 120);
    step(mk(0, 0, 1, 16'h0300, 0, 1, 16'h0300, 1, 0, 16'h0000, 16'h0000), 121);

    // Wrap: odd target is aligned down to FFFE, PC+2 wraps to 0000.
    step(mk(0, 0, 1, 16'hFFFF, 0, 1, 16'hFFFE, 1, 0, 16'h0000, 16'h0000), 130);
    step(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'hABCD, 16'hFFFE), 131);
    step(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 16'h1111, 16'h0000), 132);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_pc_fetch_stage
`default_nettype wire
